// File: rtl/riscv_pkg.sv
// Shared RV32I encodings for the decode stage: opcodes, control field encodings
// and the immediate sign extender.
package riscv_pkg;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_e;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_J = 2'b11
  } imm_src_e;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_e;

  // Opcode bits are not needed, so only Instr[31:7] is passed in.
  function automatic logic [31:0] imm_extend(input logic [31:7] ins, input imm_src_e src);
    logic [31:0] imm;
    case (src)
      IMM_S:   imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      IMM_B:   imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      IMM_J:   imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default: imm = {{20{ins[31]}}, ins[31:20]};
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/register_file.sv
// 32x32 architectural register file: two combinational reads, one clocked write,
// x0 hardwired to zero and write-through bypass from the writeback port.
module register_file (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic [4:0]  A3,
  input  logic        WE3,
  input  logic [31:0] WD3,
  output logic [31:0] RD1,
  output logic [31:0] RD2
);

  logic [31:0] regs [32];
  logic        wr_en;

  assign wr_en = WE3 && (A3 != 5'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[A3] <= WD3;
    end
  end

  // Bypass lets the same-edge ID/EX capture see the value being written.
  always_comb begin
    RD1 = regs[A1];
    RD2 = regs[A2];
    if (wr_en && (A1 == A3)) RD1 = WD3;
    if (wr_en && (A2 == A3)) RD2 = WD3;
    if (A1 == 5'd0) RD1 = '0;
    if (A2 == 5'd0) RD2 = '0;
  end

endmodule

// File: rtl/decode_cycle.sv
// RISC-V ID stage: main/ALU decode, register read, immediate extension and the
// ID/EX pipeline register feeding execute.
module decode_cycle
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] InstrD,
  input  logic [31:0] PCD,
  input  logic [31:0] PCPlus4D,
  input  logic        RegWriteW,
  input  logic [4:0]  RDW,
  input  logic [31:0] ResultW,
  input  logic        FlushE,
  output logic        RegWriteE,
  output logic        MemWriteE,
  output logic        ALUSrcE,
  output logic        BranchE,
  output logic        JumpE,
  output logic [1:0]  ResultSrcE,
  output logic [2:0]  ALUControlE,
  output logic [31:0] RD1E,
  output logic [31:0] RD2E,
  output logic [31:0] ImmExtE,
  output logic [31:0] PCE,
  output logic [31:0] PCPlus4E,
  output logic [4:0]  RS1E,
  output logic [4:0]  RS2E,
  output logic [4:0]  RDE
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        reg_write_p0;
  logic        mem_write_p0;
  logic        alu_src_p0;
  logic        branch_p0;
  logic        jump_p0;
  result_src_e result_src_p0;
  imm_src_e    imm_src_p0;
  alu_op_e     alu_op_p0;
  alu_ctrl_e   alu_ctrl_p0;
  logic [31:0] rd1_p0;
  logic [31:0] rd2_p0;
  logic [31:0] imm_p0;

  assign opcode = InstrD[6:0];
  assign funct3 = InstrD[14:12];

  always_comb begin
    reg_write_p0  = 1'b0;
    mem_write_p0  = 1'b0;
    alu_src_p0    = 1'b0;
    branch_p0     = 1'b0;
    jump_p0       = 1'b0;
    result_src_p0 = RES_ALU;
    imm_src_p0    = IMM_I;
    alu_op_p0     = ALUOP_ADD;
    case (opcode)
      OP_R: begin
        reg_write_p0 = 1'b1;
        alu_op_p0    = ALUOP_FUNCT;
      end
      OP_I: begin
        reg_write_p0 = 1'b1;
        alu_src_p0   = 1'b1;
        alu_op_p0    = ALUOP_FUNCT;
      end
      OP_LW: begin
        reg_write_p0  = 1'b1;
        alu_src_p0    = 1'b1;
        result_src_p0 = RES_MEM;
      end
      OP_SW: begin
        mem_write_p0 = 1'b1;
        alu_src_p0   = 1'b1;
        imm_src_p0   = IMM_S;
      end
      OP_BEQ: begin
        branch_p0  = 1'b1;
        imm_src_p0 = IMM_B;
        alu_op_p0  = ALUOP_SUB;
      end
      OP_JAL: begin
        reg_write_p0  = 1'b1;
        jump_p0       = 1'b1;
        result_src_p0 = RES_PC4;
        imm_src_p0    = IMM_J;
      end
      default: ;
    endcase
  end

  // funct7[5] only selects sub for register-register ops; addi never subtracts.
  always_comb begin
    alu_ctrl_p0 = ALU_ADD;
    case (alu_op_p0)
      ALUOP_SUB: alu_ctrl_p0 = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  alu_ctrl_p0 = (opcode == OP_R && InstrD[30]) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_ctrl_p0 = ALU_SLT;
          3'b110:  alu_ctrl_p0 = ALU_OR;
          3'b111:  alu_ctrl_p0 = ALU_AND;
          default: alu_ctrl_p0 = ALU_ADD;
        endcase
      end
      default: alu_ctrl_p0 = ALU_ADD;
    endcase
  end

  assign imm_p0 = imm_extend(InstrD[31:7], imm_src_p0);

  register_file u_rf (
    .clk (clk),
    .rst (rst),
    .A1  (InstrD[19:15]),
    .A2  (InstrD[24:20]),
    .A3  (RDW),
    .WE3 (RegWriteW),
    .WD3 (ResultW),
    .RD1 (rd1_p0),
    .RD2 (rd2_p0)
  );

  // ID/EX boundary: reset beats flush, flush beats load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst || FlushE) begin
      RegWriteE   <= 1'b0;
      MemWriteE   <= 1'b0;
      ALUSrcE     <= 1'b0;
      BranchE     <= 1'b0;
      JumpE       <= 1'b0;
      ResultSrcE  <= '0;
      ALUControlE <= '0;
      RD1E        <= '0;
      RD2E        <= '0;
      ImmExtE     <= '0;
      PCE         <= '0;
      PCPlus4E    <= '0;
      RS1E        <= '0;
      RS2E        <= '0;
      RDE         <= '0;
    end else begin
      RegWriteE   <= reg_write_p0;
      MemWriteE   <= mem_write_p0;
      ALUSrcE     <= alu_src_p0;
      BranchE     <= branch_p0;
      JumpE       <= jump_p0;
      ResultSrcE  <= result_src_p0;
      ALUControlE <= alu_ctrl_p0;
      RD1E        <= rd1_p0;
      RD2E        <= rd2_p0;
      ImmExtE     <= imm_p0;
      PCE         <= PCD;
      PCPlus4E    <= PCPlus4D;
      RS1E        <= InstrD[19:15];
      RS2E        <= InstrD[24:20];
      RDE         <= InstrD[11:7];
    end
  end

endmodule

// File: tb/tb_decode_cycle.sv
// Scoreboard bench for decode_cycle: an independent reference decoder and
// register model predict every ID/EX capture one cycle ahead.
module tb_decode_cycle;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] InstrD, PCD, PCPlus4D, ResultW;
  logic        RegWriteW, FlushE;
  logic [4:0]  RDW;
  logic        RegWriteE, MemWriteE, ALUSrcE, BranchE, JumpE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
  logic [4:0]  RS1E, RS2E, RDE;

  typedef struct packed {
    logic        reg_write, mem_write, alu_src, branch, jump;
    logic [1:0]  result_src;
    logic [2:0]  alu_ctrl;
    logic [31:0] rd1, rd2, imm, pc, pc4;
    logic [4:0]  rs1, rs2, rd;
  } dec_t;

  dec_t        sb[$];
  dec_t        e;
  logic [31:0] regs_m [32];
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  decode_cycle dut (
    .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(ResultW), .FlushE(FlushE),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ALUSrcE(ALUSrcE),
    .BranchE(BranchE), .JumpE(JumpE), .ResultSrcE(ResultSrcE),
    .ALUControlE(ALUControlE), .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE),
    .PCE(PCE), .PCPlus4E(PCPlus4E), .RS1E(RS1E), .RS2E(RS2E), .RDE(RDE)
  );

  function automatic dec_t got();
    return {RegWriteE, MemWriteE, ALUSrcE, BranchE, JumpE, ResultSrcE, ALUControlE,
            RD1E, RD2E, ImmExtE, PCE, PCPlus4E, RS1E, RS2E, RDE};
  endfunction

  function automatic logic [31:0] rf_read(input logic [4:0] a, input logic rw,
                                          input logic [4:0] rdw, input logic [31:0] resw);
    if (a == 5'd0) return 32'd0;
    if (rw && rdw == a) return resw;
    return regs_m[a];
  endfunction

  function automatic logic [2:0] funct_alu(input logic [2:0] f3, input logic sub_ok);
    case (f3)
      3'b000:  return sub_ok ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic dec_t ref_model(input logic [31:0] ins, pc, input logic fl, rw,
                                     input logic [4:0] rdw, input logic [31:0] resw);
    dec_t r;
    r = '0;
    if (fl) return r;
    r.pc  = pc;
    r.pc4 = pc + 32'd4;
    r.rs1 = ins[19:15];
    r.rs2 = ins[24:20];
    r.rd  = ins[11:7];
    r.rd1 = rf_read(ins[19:15], rw, rdw, resw);
    r.rd2 = rf_read(ins[24:20], rw, rdw, resw);
    r.imm = {{20{ins[31]}}, ins[31:20]};
    case (ins[6:0])
      7'h33: begin r.reg_write = 1; r.alu_ctrl = funct_alu(ins[14:12], ins[30]); end
      7'h13: begin r.reg_write = 1; r.alu_src = 1; r.alu_ctrl = funct_alu(ins[14:12], 1'b0); end
      7'h03: begin r.reg_write = 1; r.alu_src = 1; r.result_src = 2'b01; end
      7'h23: begin
        r.mem_write = 1; r.alu_src = 1;
        r.imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      end
      7'h63: begin
        r.branch = 1; r.alu_ctrl = 3'b001;
        r.imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      end
      7'h6F: begin
        r.reg_write = 1; r.jump = 1; r.result_src = 2'b10;
        r.imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      end
      default: ;
    endcase
    return r;
  endfunction

  // Applies one cycle of inputs at a falling edge, predicts the capture and
  // returns at the next falling edge with the capture visible.
  task automatic drive(input logic [31:0] ins, pc, input logic fl, rw,
                       input logic [4:0] rdw, input logic [31:0] resw);
    InstrD = ins; PCD = pc; PCPlus4D = pc + 32'd4;
    FlushE = fl; RegWriteW = rw; RDW = rdw; ResultW = resw;
    sb.push_back(ref_model(ins, pc, fl, rw, rdw, resw));
    @(posedge clk);
    if (rw && rdw != 5'd0) regs_m[rdw] = resw;
    @(negedge clk);
    FlushE = 1'b0; RegWriteW = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; InstrD = 32'h00028333; PCD = 32'h100; PCPlus4D = 32'h104;
    FlushE = 1'b0; RegWriteW = 1'b1; RDW = 5'd5; ResultW = 32'hFFFF_FFFF;
    for (int i = 0; i < 32; i++) regs_m[i] = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (got() !== dec_t'(0)) begin
      n_bad++; $display("FAIL reset_outputs got=%h required=0", got());
    end
    RegWriteW = 1'b0;
    rst = 1'b1;
    for (int i = 1; i < 32; i++) begin
      drive({7'd0, 5'(i), 5'(i), 3'd0, 5'd0, 7'h33}, 32'h200 + 32'(4 * i), 0, 0, 0, 0);
      e = sb.pop_front();
      n_cmp++;
      if (got() !== e || RD1E !== 32'd0 || RD2E !== 32'd0) begin
        n_bad++; $display("FAIL reset_reg_x%0d got=%h required=%h", i, got(), e);
      end
    end
  endtask

  task automatic test_write_read();
    drive(32'h00000013, 32'h300, 0, 1, 5'd5, 32'hDEADBEEF);
    e = sb.pop_front();
    n_cmp++;
    if (got() !== e) begin n_bad++; $display("FAIL wr_nop got=%h required=%h", got(), e); end
    drive(32'h00028333, 32'h304, 0, 0, 0, 0);
    e = sb.pop_front();
    n_cmp++;
    if (got() !== e) begin n_bad++; $display("FAIL wr_sb got=%h required=%h", got(), e); end
    n_cmp++;
    if (RD1E !== 32'hDEADBEEF || RDE !== 5'd6 || ALUControlE !== 3'b000 ||
        RegWriteE !== 1'b1 || ALUSrcE !== 1'b0) begin
      n_bad++;
      $display("FAIL wr_fields rd1=%h rde=%0d alu=%b rw=%b src=%b required deadbeef 6 000 1 0",
               RD1E, RDE, ALUControlE, RegWriteE, ALUSrcE);
    end
  endtask

  task automatic test_bypass();
    drive(32'h00028333, 32'h400, 0, 1, 5'd5, 32'h12345678);
    e = sb.pop_front();
    n_cmp++;
    if (got() !== e) begin n_bad++; $display("FAIL bypass_sb got=%h required=%h", got(), e); end
    n_cmp++;
    if (RD1E !== 32'h12345678) begin
      n_bad++; $display("FAIL bypass_rd1 got=%h required=12345678", RD1E);
    end
  endtask

  task automatic test_x0();
    drive(32'h00000013, 32'h500, 0, 1, 5'd0, 32'h1234);
    e = sb.pop_front();
    n_cmp++;
    if (got() !== e || RD1E !== 32'd0) begin
      n_bad++; $display("FAIL x0_bypass got=%h required=%h", got(), e);
    end
    drive(32'h00000333, 32'h504, 0, 0, 0, 0);
    e = sb.pop_front();
    n_cmp++;
    if (got() !== e || RD1E !== 32'd0 || RD2E !== 32'd0) begin
      n_bad++; $display("FAIL x0_read got=%h required=%h", got(), e);
    end
  endtask

  task automatic test_s_imm();
    drive(32'hFE20AE23, 32'h600, 0, 0, 0, 0);
    e = sb.pop_front();
    n_cmp++;
    if (got() !== e) begin n_bad++; $display("FAIL simm_sb got=%h required=%h", got(), e); end
    n_cmp++;
    if (ImmExtE !== 32'hFFFFFFFC || MemWriteE !== 1'b1 || ALUSrcE !== 1'b1 ||
        RegWriteE !== 1'b0 || ALUControlE !== 3'b000 || RS1E !== 5'd1 || RS2E !== 5'd2) begin
      n_bad++;
      $display("FAIL simm_fields imm=%h mw=%b src=%b rw=%b alu=%b rs1=%0d rs2=%0d required fffffffc 1 1 0 000 1 2",
               ImmExtE, MemWriteE, ALUSrcE, RegWriteE, ALUControlE, RS1E, RS2E);
    end
  endtask

  task automatic test_flush_unknown();
    drive(32'h00028333, 32'h700, 1, 0, 0, 0);
    e = sb.pop_front();
    n_cmp++;
    if (got() !== e || {RegWriteE, MemWriteE, ALUSrcE, BranchE, JumpE, ResultSrcE, ALUControlE} !== 10'd0) begin
      n_bad++; $display("FAIL flush got=%h required=%h", got(), e);
    end
    drive(32'hFFFFFFFF, 32'h704, 0, 0, 0, 0);
    e = sb.pop_front();
    n_cmp++;
    if (got() !== e || {RegWriteE, MemWriteE, ALUSrcE, BranchE, JumpE, ResultSrcE, ALUControlE} !== 10'd0) begin
      n_bad++; $display("FAIL unknown_op got=%h required=%h", got(), e);
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0]  ops [7] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h57};
    logic [31:0] ins;
    logic [4:0]  rdw;
    for (int n = 0; n < 80; n++) begin
      ins = {$urandom(), 7'd0} | 32'(ops[$urandom_range(0, 6)]);
      rdw = ($urandom_range(0, 2) == 0) ? ins[19:15] : 5'($urandom());
      drive(ins, $urandom(), ($urandom_range(0, 7) == 0), $urandom_range(0, 1) == 1,
            rdw, $urandom());
      e = sb.pop_front();
      n_cmp++;
      if (got() !== e) begin
        n_bad++; $display("FAIL b2b_%0d instr=%h got=%h required=%h", n, ins, got(), e);
      end
    end
  endtask

  task automatic test_mid_reset();
    drive(32'h00000013, 32'h800, 0, 1, 5'd7, 32'hCAFE0007);
    void'(sb.pop_front());
    drive(32'h0003A383, 32'h804, 0, 0, 0, 0);
    e = sb.pop_front();
    n_cmp++;
    if (got() !== e || RD1E !== 32'hCAFE0007) begin
      n_bad++; $display("FAIL pre_reset got=%h required=%h", got(), e);
    end
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if (got() !== dec_t'(0)) begin
      n_bad++; $display("FAIL async_reset got=%h required=0", got());
    end
    for (int i = 0; i < 32; i++) regs_m[i] = '0;
    @(negedge clk);
    rst = 1'b1;
    drive(32'h0003A383, 32'h808, 0, 0, 0, 0);
    e = sb.pop_front();
    n_cmp++;
    if (got() !== e || RD1E !== 32'd0) begin
      n_bad++; $display("FAIL post_reset_x7 got=%h required=%h", got(), e);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_x0();
    test_s_imm();
    test_flush_unknown();
    test_back_to_back();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
